// File: rtl/memory_master_pkg.sv
`default_nettype none
// ============================================================================
// memory_master_pkg : shared types, defaults and sizing helper
// Revision 1.0
// ============================================================================
package memory_master_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_CNT_W  = 13;
   localparam int DEF_DLY_W  = 8;
   localparam int DEF_N_STOP = 2;
   localparam bit DEF_CIRC   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECORD = 2'd1,
      ST_POST   = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Width of a counter that must hold 0..n_stop inclusive.
   function automatic int slot_w(input int n_stop);
      return (n_stop < 1) ? 1 : $clog2(n_stop + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/memory_master_mc_stop_capture.sv
`default_nettype none
// ============================================================================
// stop_capture : stop edge detector and per-stop coord/pointer capture bank
// Revision 1.0
// ============================================================================
module stop_capture
   import memory_master_pkg::*;
#(
   parameter int N_STOP = DEF_N_STOP,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      capture_en,
   input  logic                      stop,
   input  logic [ADDR_W-1:0]         ptr,
   input  logic [CNT_W-1:0]          coarse_counter,
   output logic                      stop_hit,
   output logic                      stop_detected,
   output logic [slot_w(N_STOP)-1:0] stop_count,
   output logic [N_STOP*CNT_W-1:0]   slot_coord,
   output logic [N_STOP*ADDR_W-1:0]  slot_ptr
);

   localparam int SC_W = slot_w(N_STOP);

   logic              stop_prev_q, stop_prev_d;
   logic              detected_q, detected_d;
   logic [SC_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]  coord_q [N_STOP];
   logic [CNT_W-1:0]  coord_d [N_STOP];
   logic [ADDR_W-1:0] sptr_q  [N_STOP];
   logic [ADDR_W-1:0] sptr_d  [N_STOP];

   always_comb begin
      stop_hit    = capture_en && stop && !stop_prev_q && (count_q < SC_W'(N_STOP));
      stop_prev_d = stop;
      detected_d  = detected_q;
      count_d     = count_q;
      coord_d     = coord_q;
      sptr_d      = sptr_q;
      if (clear) begin
         detected_d = 1'b0;
         count_d    = '0;
         for (int k = 0; k < N_STOP; k++) begin
            coord_d[k] = '0;
            sptr_d[k]  = '0;
         end
      end else if (stop_hit) begin
         detected_d = 1'b1;
         count_d    = count_q + 1'b1;
         for (int k = 0; k < N_STOP; k++) begin
            if (count_q == SC_W'(k)) begin
               coord_d[k] = coarse_counter;
               sptr_d[k]  = ptr;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stop_prev_q <= 1'b0;
         detected_q  <= 1'b0;
         count_q     <= '0;
         for (int k = 0; k < N_STOP; k++) begin
            coord_q[k] <= '0;
            sptr_q[k]  <= '0;
         end
      end else begin
         stop_prev_q <= stop_prev_d;
         detected_q  <= detected_d;
         count_q     <= count_d;
         coord_q     <= coord_d;
         sptr_q      <= sptr_d;
      end
   end

   for (genvar k = 0; k < N_STOP; k++) begin : g_flat
      assign slot_coord[k*CNT_W +: CNT_W]  = coord_q[k];
      assign slot_ptr[k*ADDR_W +: ADDR_W]  = sptr_q[k];
   end

   assign stop_detected = detected_q;
   assign stop_count    = count_q;

endmodule
`default_nettype wire

// File: rtl/memory_master_mc.sv
`default_nettype none
// ============================================================================
// memory_master_mc : multi-stop Avalon-MM sample RAM write master
// Revision 1.0
// ============================================================================
module memory_master_mc
   import memory_master_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int DLY_W  = DEF_DLY_W,
   parameter int N_STOP = DEF_N_STOP,
   parameter bit CIRC   = DEF_CIRC
) (
   input  logic                      ref_clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      stop,
   input  logic [DLY_W-1:0]          stop_delay,
   input  logic [CNT_W-1:0]          coarse_counter,
   output logic                      av_cs,
   output logic                      av_write,
   output logic [ADDR_W-1:0]         av_addr,
   output logic [ADDR_W-1:0]         ram_ptr,
   output logic                      stop_detected,
   output logic [slot_w(N_STOP)-1:0] stop_count,
   output logic                      buffer_full,
   output logic                      wrapped,
   output logic [ADDR_W:0]           sample_size,
   output logic [N_STOP*CNT_W-1:0]   pulse_abs_coord,
   output logic [N_STOP*ADDR_W-1:0]  pulse_ptr
);

   localparam int                SC_W      = slot_w(N_STOP);
   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
   localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              av_cs_q, av_cs_d;
   logic              full_q, full_d;
   logic              wrapped_q, wrapped_d;
   logic [ADDR_W:0]   size_q, size_d;
   logic [DLY_W-1:0]  dly_q, dly_d;

   logic              clear, capture_en, stop_hit, last_stop, at_end, final_wr;
   logic [SC_W-1:0]   cap_count;

   stop_capture #(
      .N_STOP (N_STOP),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_stop_capture (
      .clk            (ref_clk),
      .reset          (reset),
      .clear          (clear),
      .capture_en     (capture_en),
      .stop           (stop),
      .ptr            (ptr_q),
      .coarse_counter (coarse_counter),
      .stop_hit       (stop_hit),
      .stop_detected  (stop_detected),
      .stop_count     (cap_count),
      .slot_coord     (pulse_abs_coord),
      .slot_ptr       (pulse_ptr)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      av_cs_d    = av_cs_q;
      full_d     = full_q;
      wrapped_d  = wrapped_q;
      size_d     = size_q;
      dly_d      = dly_q;
      clear      = 1'b0;
      final_wr   = 1'b0;
      capture_en = (state_q == ST_RECORD);
      last_stop  = stop_hit && (cap_count == SC_W'(N_STOP - 1));
      at_end     = !CIRC && (ptr_q == LAST_ADDR);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               clear     = 1'b1;
               state_d   = ST_RECORD;
               ptr_d     = '0;
               av_cs_d   = 1'b1;
               full_d    = 1'b0;
               wrapped_d = 1'b0;
               size_d    = '0;
               dly_d     = '0;
            end
         end
         ST_RECORD: begin
            if (last_stop) begin
               dly_d = stop_delay;
               if (stop_delay == '0) final_wr = 1'b1;
               else                  state_d  = ST_POST;
            end
            if (at_end) final_wr = 1'b1;
         end
         default: begin
            dly_d = dly_q - 1'b1;
            if ((dly_q == DLY_W'(1)) || at_end) final_wr = 1'b1;
         end
      endcase

      // Every cycle with chip select high is one completed write.
      if (av_cs_q) begin
         if (size_q != DEPTH_CNT) size_d = size_q + 1'b1;
         if (final_wr) begin
            state_d = ST_DONE;
            av_cs_d = 1'b0;
            full_d  = 1'b1;
         end else begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST_ADDR) wrapped_d = 1'b1;
         end
      end
   end

   always_ff @(posedge ref_clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         av_cs_q   <= 1'b0;
         full_q    <= 1'b0;
         wrapped_q <= 1'b0;
         size_q    <= '0;
         dly_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         av_cs_q   <= av_cs_d;
         full_q    <= full_d;
         wrapped_q <= wrapped_d;
         size_q    <= size_d;
         dly_q     <= dly_d;
      end
   end

   assign av_cs       = av_cs_q;
   assign av_write    = av_cs_q;
   assign av_addr     = ptr_q;
   assign ram_ptr     = ptr_q;
   assign buffer_full = full_q;
   assign wrapped     = wrapped_q;
   assign sample_size = size_q;
   assign stop_count  = cap_count;

endmodule
`default_nettype wire

// File: doc/memory_master_mc.md
# memory_master_mc

Parametrised multi-stop successor of the rangefinder memory master. On a start pulse it drives an Avalon-MM write stream into the sample RAM, one address per clock. It time-stamps up to N_STOP stop pulses with the coarse counter and RAM pointer, and keeps writing for a programmable post-stop delay after the last one. It adds circular (pre-trigger) or linear recording, configurable depth and counter width, and per-stop capture banks for the host status registers.

## Interface
- ADDR_W, 8: RAM address width; DEPTH = 2^ADDR_W.
- CNT_W, 13: coarse counter width.
- DLY_W, 8: stop_delay width.
- N_STOP, 2: number of stop pulses captured (1..8).
- CIRC, 1: 1 = circular overwrite; 0 = linear, halt at full.

Ports:
- ref_clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  start-recording pulse.
- stop  in  1  stop pulse, edge-detected.
- stop_delay  in  DLY_W  writes after the final stop.
- coarse_counter  in  CNT_W  free-running time base.
- av_cs, av_write  out  1  Avalon chip select / write, always equal.
- av_addr  out  ADDR_W  write address.
- ram_ptr  out  ADDR_W  current or last write address.
- stop_detected  out  1  at least one stop captured.
- stop_count  out  $clog2(N_STOP+1)  stops captured.
- buffer_full  out  1  recording finished.
- wrapped  out  1  pointer has wrapped at least once (CIRC=1).
- sample_size  out  ADDR_W+1  writes since start, saturating at DEPTH.
- pulse_abs_coord  out  N_STOP*CNT_W  captured coarse_counter per stop; slot k in bits [k*CNT_W +: CNT_W].
- pulse_ptr  out  N_STOP*ADDR_W  captured ram_ptr per stop.

## Operation
- States: IDLE, RECORD, POST, DONE.
- IDLE: start=1 clears all status, sets ptr=0, goes to RECORD. stop is ignored.
- RECORD: one write per cycle at av_addr=ptr. ptr increments mod DEPTH. Wrap sets wrapped. sample_size increments and saturates at DEPTH.
- stop rising edge (stop=1 and previous cycle stop=0) in RECORD, with stop_count<N_STOP:
  - slot[stop_count] latches coarse_counter and the ptr of the current write;
  - stop_count increments; stop_detected is set.
- On the N_STOP-th stop: latch stop_delay and go to POST. With stop_delay=0, go straight to DONE; the write in the stop cycle is the last write.
- POST: exactly stop_delay further writes, then DONE. Last written address = captured ptr + stop_delay mod DEPTH.
- CIRC=0: the write to address DEPTH-1 is the final one. Go to DONE from RECORD or POST; remaining stops are not captured.
- DONE: av_cs=av_write=0, buffer_full=1. Status holds. start=1 restarts exactly as from IDLE. stop is ignored.
- start during RECORD/POST is ignored.
- Same-cycle start and stop in IDLE/DONE: start is honoured, stop is ignored.
- Unused capture slots read 0.
- reset at any time: all outputs 0, state IDLE; the next start is accepted on the cycle after reset deasserts.

## Timing
- All outputs are registered; reset value 0 for every output.
- start sampled at edge t → av_cs=1, av_addr=0 during cycle t+1.
- stop sampled at edge s → pulse_* valid and stop_count updated from edge s+1. Captured ptr = av_addr during the cycle preceding edge s.
- Final write with av_cs=1 → buffer_full=1 and av_cs=0 from the next edge.
- ram_ptr equals av_addr while writing and holds the last written address in DONE.

## Structure
- Package memory_master_pkg holds:
  - the state enum;
  - the slot-index width function;
  - default parameter constants.
- Sub-module stop_capture: stop edge detector plus N_STOP-deep capture bank. It takes capture_en, ptr and coarse_counter, and outputs stop_count and the flattened slots.
- The top level holds the FSM, pointer, sample and delay counters.

## Test plan
- ADDR_W=8, CIRC=1, N_STOP=2, stop_delay=16, 10 ns clock. start at 150 ns, stops 5000 ns and 6000 ns apart → pulse_ptr slots show the correct mod-256 addresses, wrapped=1, exactly 16 writes after the second stop, buffer_full=1, sample_size=256.
- CIRC=0, single stop never issued → writes 0..255, then buffer_full=1, stop_count=0, sample_size=256.
- stop_delay=0 with a stop at ptr=37 → last av_addr=37, av_cs low from the next cycle.
- stop held high 5 cycles → counts as one stop. Stop in IDLE, and stop coincident with start → ignored, stop_count=0.
- Reset asserted mid-POST, then stop_delay=32 and restart → all status cleared. Second run captures fresh coords; exactly 32 post writes.
- start during RECORD ignored; start in DONE restarts at av_addr=0 with status cleared.
